// File: rtl/pcr_host_master.sv
// pcr_host_master
// Bridges a host command channel to a PCR register file, one command at a time.
// A captured command is presented to the PCR file, read data (or a timeout
// error) is collected, and a single completion is returned to the host.
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clk edge where valid and ready are both high. The sender keeps valid and its
// payload stable until that edge; ready may rise or fall freely.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   host_req_valid/ready          host command channel
//   host_req_rw/addr/data         command payload (1 = write, 0 = read)
//   pcr_req_valid/ready           request channel to the PCR file
//   pcr_req_rw/addr/data          registered copy of the captured command
//   pcr_resp_valid/data           read data from the PCR file (WAIT only)
//   host_resp_valid/ready         completion channel to the host
//   host_resp_data/err            read data, err = read timed out
//   busy                          high whenever not IDLE
//   state_dbg                     current FSM state (0 IDLE,1 REQ,2 WAIT,3 RESP)
module pcr_host_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_rw,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_data,
    output logic              pcr_req_valid,
    input  logic              pcr_req_ready,
    output logic              pcr_req_rw,
    output logic [ADDR_W-1:0] pcr_req_addr,
    output logic [DATA_W-1:0] pcr_req_data,
    input  logic              pcr_resp_valid,
    input  logic [DATA_W-1:0] pcr_resp_data,
    output logic              host_resp_valid,
    input  logic              host_resp_ready,
    output logic [DATA_W-1:0] host_resp_data,
    output logic              host_resp_err,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (host_req_valid) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (pcr_req_ready) state_nxt = pcr_req_rw ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (pcr_resp_valid || (wait_cnt == TIMEOUT_C)) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (host_resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so no input reaches an output
    // combinationally.
    always_comb begin
        host_req_ready  = (state == ST_IDLE);
        pcr_req_valid   = (state == ST_REQ);
        host_resp_valid = (state == ST_RESP);
        busy            = (state != ST_IDLE);
        state_dbg       = state;
    end

    // Command capture, timeout counter and completion registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcr_req_rw     <= 1'b0;
            pcr_req_addr   <= '0;
            pcr_req_data   <= '0;
            host_resp_data <= '0;
            host_resp_err  <= 1'b0;
            wait_cnt       <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_req_valid) begin
                        pcr_req_rw   <= host_req_rw;
                        pcr_req_addr <= host_req_addr;
                        pcr_req_data <= host_req_data;
                    end
                end
                ST_REQ: begin
                    if (pcr_req_ready) begin
                        wait_cnt <= 8'd0;
                        // Writes complete immediately with an all-zero,
                        // error-free completion.
                        if (pcr_req_rw) begin
                            host_resp_data <= '0;
                            host_resp_err  <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    // A response in the timeout cycle wins over the timeout.
                    if (pcr_resp_valid) begin
                        host_resp_data <= pcr_resp_data;
                        host_resp_err  <= 1'b0;
                    end else if (wait_cnt == TIMEOUT_C) begin
                        host_resp_data <= '0;
                        host_resp_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcr_host_master.sv
module tb_pcr_host_master;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int TO     = 255;
    localparam int TO1    = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // ---------------- DUT signals ----------------
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_rw;
    logic [ADDR_W-1:0] host_req_addr;
    logic [DATA_W-1:0] host_req_data;
    logic              pcr_req_valid;
    logic              pcr_req_ready;
    logic              pcr_req_rw;
    logic [ADDR_W-1:0] pcr_req_addr;
    logic [DATA_W-1:0] pcr_req_data;
    logic              pcr_resp_valid;
    logic [DATA_W-1:0] pcr_resp_data;
    logic              host_resp_valid;
    logic              host_resp_ready;
    logic [DATA_W-1:0] host_resp_data;
    logic              host_resp_err;
    logic              busy;
    logic [1:0]        state_dbg;

    // second instance with TIMEOUT=1, own request valid, shared payload inputs
    logic              t1_req_valid;
    logic              t1_req_ready;
    logic              t1_pcr_req_valid;
    logic              t1_pcr_req_rw;
    logic [ADDR_W-1:0] t1_pcr_req_addr;
    logic [DATA_W-1:0] t1_pcr_req_data;
    logic              t1_resp_valid;
    logic [DATA_W-1:0] t1_resp_data;
    logic              t1_resp_err;
    logic              t1_busy;
    logic [1:0]        t1_state_dbg;

    pcr_host_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_rw(host_req_rw), .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready),
        .pcr_req_rw(pcr_req_rw), .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
        .pcr_resp_valid(pcr_resp_valid), .pcr_resp_data(pcr_resp_data),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_data(host_resp_data), .host_resp_err(host_resp_err),
        .busy(busy), .state_dbg(state_dbg)
    );

    pcr_host_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO1)) u_dut_t1 (
        .clk(clk), .reset_n(reset_n),
        .host_req_valid(t1_req_valid), .host_req_ready(t1_req_ready),
        .host_req_rw(host_req_rw), .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .pcr_req_valid(t1_pcr_req_valid), .pcr_req_ready(pcr_req_ready),
        .pcr_req_rw(t1_pcr_req_rw), .pcr_req_addr(t1_pcr_req_addr), .pcr_req_data(t1_pcr_req_data),
        .pcr_resp_valid(pcr_resp_valid), .pcr_resp_data(pcr_resp_data),
        .host_resp_valid(t1_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_data(t1_resp_data), .host_resp_err(t1_resp_err),
        .busy(t1_busy), .state_dbg(t1_state_dbg)
    );

    // ---------------- scoreboard ----------------
    // entry = {err, data}
    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] exp_q1[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compare on every completion handshake of the main DUT
    always @(negedge clk) begin
        logic [DATA_W:0] got;
        logic [DATA_W:0] exp_v;
        if (reset_n && host_resp_valid && host_resp_ready) begin
            got = {host_resp_err, host_resp_data};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got %0h expected none", got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL resp_data_err: got %0h expected %0h", got, exp_v);
                end
            end
        end
    end

    // monitor for the TIMEOUT=1 instance
    always @(negedge clk) begin
        logic [DATA_W:0] got;
        logic [DATA_W:0] exp_v;
        if (reset_n && t1_resp_valid && host_resp_ready) begin
            got = {t1_resp_err, t1_resp_data};
            n_tests++;
            if (exp_q1.size() == 0) begin
                n_fail++;
                $display("FAIL t1_resp_unexpected: got %0h expected none", got);
            end else begin
                exp_v = exp_q1.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL t1_resp_data_err: got %0h expected %0h", got, exp_v);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is just after a rising edge with the DUT idle; the command is
    // accepted on the next rising edge.
    task automatic send_cmd(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        host_req_valid = 1'b1;
        host_req_rw    = rw;
        host_req_addr  = addr;
        host_req_data  = data;
        tick();
        host_req_valid = 1'b0;
    endtask

    // Returns the index (1 = first falling edge after the accept edge) at
    // which host_resp_valid is first seen; 0 when the budget runs out.
    task automatic wait_resp(input bit sel, input int bound, output int idx);
        idx = 0;
        for (int j = 1; j <= bound && idx == 0; j++) begin
            @(negedge clk);
            if (sel ? t1_resp_valid : host_resp_valid) idx = j;
            tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_host_req_ready"}, host_req_ready, 1);
        check({tag, "_pcr_req_valid"}, pcr_req_valid, 0);
        check({tag, "_host_resp_valid"}, host_resp_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pcr_req_rw"}, pcr_req_rw, 0);
        check({tag, "_pcr_req_addr"}, pcr_req_addr, 0);
        check({tag, "_pcr_req_data"}, pcr_req_data, 0);
        check({tag, "_host_resp_data"}, host_resp_data, 0);
        check({tag, "_host_resp_err"}, host_resp_err, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        reset_n         = 1'b0;
        host_req_valid  = 1'b0;
        host_req_rw     = 1'b0;
        host_req_addr   = '0;
        host_req_data   = '0;
        pcr_req_ready   = 1'b1;
        pcr_resp_valid  = 1'b0;
        pcr_resp_data   = '0;
        host_resp_ready = 1'b1;
        t1_req_valid    = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        check_reset_vals("rst");
        tick();
        reset_n = 1'b1;

        // write, ready tied high; accepted on first edge after reset release
        exp_q.push_back({1'b0, 64'h0});
        send_cmd(1'b1, 5'h03, 64'hDEAD_BEEF);
        @(negedge clk);
        check("wr_pcr_valid", pcr_req_valid, 1);
        check("wr_pcr_rw", pcr_req_rw, 1);
        check("wr_pcr_addr", pcr_req_addr, 5'h03);
        check("wr_pcr_data", pcr_req_data, 64'hDEAD_BEEF);
        check("wr_req_ready", host_req_ready, 0);
        check("wr_busy", busy, 1);
        tick();
        @(negedge clk);
        check("wr_pcr_valid_drop", pcr_req_valid, 0);
        check("wr_resp_lat", host_resp_valid, 1);
        tick();
        @(negedge clk);
        check("wr_back_idle", host_req_ready, 1);
        tick();

        // read, ready same cycle, response next cycle -> resp at N+3
        exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
        send_cmd(1'b0, 5'h0A, 64'hFFFF_FFFF);
        @(negedge clk);
        check("rd_pcr_valid", pcr_req_valid, 1);
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check("rd_wait_state", state_dbg, 2);
        check("rd_resp_not_yet", host_resp_valid, 0);
        tick();
        pcr_resp_valid = 1'b0;
        @(negedge clk);
        check("rd_resp_lat", host_resp_valid, 1);
        tick();

        // read addr 1F, ready low 3 cycles (junk response during REQ ignored)
        exp_q.push_back({1'b0, 64'h0000_0000_0000_00A5});
        pcr_req_ready = 1'b0;
        send_cmd(1'b0, 5'h1F, 64'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                pcr_req_ready  = 1'b1;
                pcr_resp_valid = 1'b0;
            end else begin
                pcr_resp_valid = 1'b1;
                pcr_resp_data  = 64'hBAD0_BAD0;
            end
            @(negedge clk);
            check("rd1f_req_held", pcr_req_valid, 1);
            check("rd1f_addr_held", pcr_req_addr, 5'h1F);
            check("rd1f_rw_held", pcr_req_rw, 0);
            tick();
        end
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h0000_0000_0000_00A5;
        tick();
        pcr_resp_valid = 1'b0;
        @(negedge clk);
        check("rd1f_resp_valid", host_resp_valid, 1);
        tick();

        // response pulse while idle changes nothing
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h77;
        tick();
        pcr_resp_valid = 1'b0;
        @(negedge clk);
        check("idle_resp_state", state_dbg, 0);
        check("idle_resp_data", host_resp_data, 64'hA5);
        check("idle_resp_valid", host_resp_valid, 0);
        tick();

        // timeout with TIMEOUT=255
        exp_q.push_back({1'b1, 64'h0});
        send_cmd(1'b0, 5'h11, 64'h0);
        wait_resp(1'b0, TO + 20, idx);
        check("to255_latency", idx, TO + 3);

        // timeout with TIMEOUT=1
        exp_q1.push_back({1'b1, 64'h0});
        t1_req_valid  = 1'b1;
        host_req_rw   = 1'b0;
        host_req_addr = 5'h07;
        tick();
        t1_req_valid = 1'b0;
        wait_resp(1'b1, 20, idx);
        check("to1_latency", idx, TO1 + 3);

        // TIMEOUT=1: response in the exact timeout cycle wins
        exp_q1.push_back({1'b0, 64'hC0FF_EE00});
        t1_req_valid = 1'b1;
        tick();
        t1_req_valid = 1'b0;
        tick();
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'hC0FF_EE00;
        tick();
        pcr_resp_valid = 1'b0;
        @(negedge clk);
        check("to1_race_valid", t1_resp_valid, 1);
        check("to1_race_err", t1_resp_err, 0);
        tick();

        // host stalls the completion for 10 cycles while a new command waits
        host_resp_ready = 1'b0;
        exp_q.push_back({1'b0, 64'h1122_3344_5566_7788});
        send_cmd(1'b0, 5'h04, 64'h0);
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h1122_3344_5566_7788;
        tick();
        host_req_valid = 1'b1;
        host_req_rw    = 1'b1;
        host_req_addr  = 5'h02;
        host_req_data  = 64'h55;
        for (int i = 0; i < 10; i++) begin
            pcr_resp_valid = (i == 5);
            pcr_resp_data  = 64'hBAD;
            @(negedge clk);
            check("stall_valid", host_resp_valid, 1);
            check("stall_data", host_resp_data, 64'h1122_3344_5566_7788);
            check("stall_err", host_resp_err, 0);
            check("stall_req_ready", host_req_ready, 0);
            check("stall_no_accept", pcr_req_valid, 0);
            tick();
        end
        pcr_resp_valid = 1'b0;
        exp_q.push_back({1'b0, 64'h0});
        host_resp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("stall_done_idle", host_req_ready, 1);
        check("stall_done_no_req", pcr_req_valid, 0);
        tick();
        host_req_valid = 1'b0;
        @(negedge clk);
        check("stall_next_req", pcr_req_valid, 1);
        check("stall_next_addr", pcr_req_addr, 5'h02);
        check("stall_next_data", pcr_req_data, 64'h55);
        tick();
        @(negedge clk);
        check("stall_next_resp", host_resp_valid, 1);
        tick();

        // reset during WAIT
        send_cmd(1'b0, 5'h06, 64'h0);
        repeat (3) tick();
        @(negedge clk);
        check("rstw_in_wait", state_dbg, 2);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rstw");
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rstw_quiet", {busy, host_resp_valid}, 0);
            tick();
        end
        exp_q.push_back({1'b0, 64'h0});
        send_cmd(1'b1, 5'h08, 64'hABC);
        @(negedge clk);
        check("rstw_next_addr", pcr_req_addr, 5'h08);
        tick();
        @(negedge clk);
        check("rstw_next_resp", host_resp_valid, 1);
        tick();

        // reset during RESP
        host_resp_ready = 1'b0;
        send_cmd(1'b0, 5'h09, 64'h0);
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h5A5A;
        tick();
        pcr_resp_valid = 1'b0;
        @(negedge clk);
        check("rstr_in_resp", host_resp_data, 64'h5A5A);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rstr");
        tick();
        reset_n = 1'b1;
        host_resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rstr_quiet", {busy, host_resp_valid}, 0);
            tick();
        end
        exp_q.push_back({1'b0, 64'hFEED});
        send_cmd(1'b0, 5'h15, 64'h0);
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'hFEED;
        tick();
        pcr_resp_valid = 1'b0;
        @(negedge clk);
        check("rstr_next_resp", host_resp_valid, 1);
        tick();

        // ---------------- final report ----------------
        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        check("queue1_drained", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcr_host_master.md
PCR_HOST_MASTER -- requirements
Module: pcr_host_master

Interface
- REQ-001: Parameter ADDR_W, default 5, PCR address width.
- REQ-002: Parameter DATA_W, default 64, PCR data width.
- REQ-003: Parameter TIMEOUT, default 255, maximum WAIT cycles before abort, range 1..255.
- REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005: reset_n  input  1  asynchronous, active-low reset.
- REQ-006: host_req_valid  input  1  host command present.
- REQ-007: host_req_ready  output  1  block accepts a host command.
- REQ-008: host_req_rw  input  1  1 = write, 0 = read.
- REQ-009: host_req_addr  input  ADDR_W  target PCR address.
- REQ-010: host_req_data  input  DATA_W  write data; ignored for reads.
- REQ-011: pcr_req_valid  output  1  request to the PCR file.
- REQ-012: pcr_req_ready  input  1  PCR file accepts the request.
- REQ-013: pcr_req_rw, pcr_req_addr, pcr_req_data  output  1/ADDR_W/DATA_W  registered copies of the captured command.
- REQ-014: pcr_resp_valid  input  1  read data returned by the PCR file.
- REQ-015: pcr_resp_data  input  DATA_W  read data.
- REQ-016: host_resp_valid  output  1  completion available to the host.
- REQ-017: host_resp_ready  input  1  host consumes the completion.
- REQ-018: host_resp_data  output  DATA_W  read data; 0 for writes and timeouts.
- REQ-019: host_resp_err  output  1  1 = read timed out.
- REQ-020: busy  output  1  high in any state other than IDLE.

Function
- REQ-021: FSM states: IDLE, REQ, WAIT, RESP; exactly one command is outstanding at a time.
- REQ-022: IDLE: host_req_ready=1. On host_req_valid, capture rw/addr/data; next state REQ.
- REQ-023: REQ: pcr_req_valid=1 and outputs held stable until pcr_req_ready is sampled high.
- REQ-024: REQ with pcr_req_ready=1 and a write: go to RESP; host_resp_data=0, err=0.
- REQ-025: REQ with pcr_req_ready=1 and a read: go to WAIT; the 8-bit timeout counter clears to 0.
- REQ-026: WAIT: the counter increments each cycle without pcr_resp_valid.
- REQ-027: WAIT with pcr_resp_valid=1: capture pcr_resp_data into host_resp_data, err=0, go to RESP.
- REQ-028: WAIT with the counter equal to TIMEOUT and no pcr_resp_valid: go to RESP; host_resp_data=0, err=1.
- REQ-029: A response and the timeout in the same cycle resolve as a response; err=0.
- REQ-030: pcr_resp_valid outside WAIT is ignored and changes no state.
- REQ-031: RESP: host_resp_valid=1 with data and err held stable. On host_resp_ready go to IDLE.
- REQ-032: host_req_ready is 0 outside IDLE; no command is accepted in the same cycle RESP completes.
- REQ-033: Minimum latency from the accept edge N: pcr_req_valid at N+1. A write gives host_resp_valid at N+2. A read with a same-cycle ready and a next-cycle response gives host_resp_valid at N+3.
- REQ-034: All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

Reset
- REQ-035: reset_n low immediately forces IDLE, including when it arrives mid-transaction. In-flight commands are dropped and no completion is issued.
- REQ-036: Reset values: host_req_ready=1, pcr_req_valid=0, host_resp_valid=0, busy=0. pcr_req_rw/addr/data=0, host_resp_data=0, host_resp_err=0, counter=0.
- REQ-037: After reset_n rises, the first command is accepted on the first rising edge with host_req_valid=1.

Verification
- REQ-038: Write, addr 5'h03, data 64'hDEAD_BEEF, pcr_req_ready tied 1 -> pcr_req_valid one cycle with those values; then host_resp_valid with data=0, err=0.
- REQ-039: Read, addr 5'h1F; pcr_req_ready low 3 cycles, then high; response 64'h0000_0000_0000_00A5 two cycles later -> req held stable for 4 cycles; host_resp_data=64'hA5, err=0.
- REQ-040: Read with no PCR response -> host_resp_valid exactly TIMEOUT+1 cycles after entering WAIT, err=1, data=0. Repeat with TIMEOUT=1.
- REQ-041: Response arriving in the exact timeout cycle -> err=0, returned data delivered.
- REQ-042: host_resp_ready held low 10 cycles -> response held stable, host_req_ready=0, a new host_req_valid is not accepted until one cycle after completion.
- REQ-043: reset_n pulsed low during WAIT and during RESP -> outputs immediately at reset values, no host_resp_valid afterwards, next command handled normally.
